ttl_decoder_scan: RTL and testbench
===================================

Name: ttl_decoder_scan

Overview:
- Parametrised registered successor to the one-of-ten BCD decoder family.
- Decodes a SEL_W-bit code onto OUTPUTS active-low lines.
- Runs in two modes: direct (code from input) or scan (internal auto-incrementing counter with programmable modulus).
- Used for strobe/column scanning of multiplexed displays, DIP/joystick matrices and chip selects, replacing discrete decoder-plus-counter pairs.

Parameters:
SEL_W, 4, width of select code and scan counter
OUTPUTS, 10, number of decoded active-low outputs; legal range 2..2**SEL_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ce  in  1  clock enable; code register updates only when ce=1
mode  in  1  0 = direct, 1 = scan
load  in  1  scan mode: load sel_in into counter on ce instead of incrementing
sel_in  in  SEL_W  direct code / scan preload value
en_n  in  1  active-low output enable (gate G)
o  out  OUTPUTS  decoded outputs, active-low, registered
cur_sel  out  SEL_W  current code register value
wrap  out  1  one-clk pulse when scan counter wraps OUTPUTS-1 -> 0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on rising clk.
- Reset values:
  - code = 0, so cur_sel = 0
  - o = all ones
  - wrap = 0
  - no pending blank state
- Reset overrides ce/load/mode in the same cycle.
- Code register, updated only on a clk edge with ce=1:
  - mode=0: code <= sel_in.
  - mode=1, load=1: code <= sel_in.
  - mode=1, load=0, code == OUTPUTS-1: code <= 0, wrap <= 1.
  - mode=1, load=0, code >= OUTPUTS (invalid, e.g. after preload): code <= 0, wrap stays 0.
  - mode=1, load=0, otherwise: code <= code + 1, held to SEL_W bits.
- wrap:
  - 0 on every clk edge not covered by the wrap rule above, including ce=0 cycles.
  - A pulse is exactly one clk wide.
- cur_sel = code register; no extra delay.
- Output register, updated every clk edge regardless of ce:
  - o <= all ones if en_n=1 or code >= OUTPUTS.
  - Otherwise o <= ~(1 << code).
- Latency:
  - sel_in/ce sampled at edge k -> cur_sel valid after edge k -> o valid after edge k+1.
  - en_n change -> o responds after 1 edge.
- At most one bit of o is low in any cycle. Invalid codes blank all outputs (matches 7442 behaviour for codes 10..15).
- en_n does not freeze the code: the counter keeps advancing on ce while outputs are blanked.
- A mode switch takes effect on the next ce edge; the counter continues from the current code.
- ce held at 0: code and wrap hold (wrap = 0); o still tracks en_n.
- OUTPUTS = 2**SEL_W: no invalid codes exist; wrap occurs at the all-ones code.

Optional Feature:
- Macro: TTL_DECODER_BREAK_BEFORE_MAKE_EN.
- Defined:
  - When the code register changes from one valid index to a different valid index, o is forced all ones for exactly one clk before the new line goes low (total o latency 2 edges for that change).
  - Reload of the same code, or entry from invalid/blanked state, adds no gap.
  - wrap and cur_sel timing are unchanged.
  - Required for scanned key matrices, to prevent two adjacent columns overlapping.
- Undefined: direct transition, latency as stated in Behaviour.

Test Plan:
- Reset with mode=1, ce=1 held, then release -> cur_sel 0 after reset; o = 10'b1111111110 one clk later; then cur_sel 1,2,..,9,0 on successive clks; wrap=1 only in the cycle cur_sel returns to 0.
- Direct mode, en_n=0, ce=1, sel_in=5 -> after 2 edges o = 10'b1111011111; sel_in=12 -> o = 10'b1111111111.
- Scan mode, load=1, sel_in=14 -> cur_sel 14, o all ones; next ce without load -> cur_sel 0, wrap stays 0, o = 10'b1111111110.
- Scan mode, en_n=1 for 4 ce pulses starting at code 2 -> o all ones throughout, cur_sel reaches 6; en_n=0 -> o = 10'b1110111111 one edge later.
- ce toggling 1/0 in scan mode -> code advances only on ce=1 edges; wrap never asserted on a ce=0 cycle; reset asserted mid-scan at code 7 -> cur_sel 0, o all ones, wrap 0 on the next edge.
- With TTL_DECODER_BREAK_BEFORE_MAKE_EN, direct change 3 -> 4 -> o sequence 10'b1111110111, 10'b1111111111, 10'b1111101111; the same stimulus without the macro shows no all-ones gap.

Source files
------------

// File: rtl/ttl_decoder_scan.sv
// rtl/ttl_decoder_scan.sv - registered one-of-N active-low decoder with direct and auto-scan modes
// Optional: TTL_DECODER_BREAK_BEFORE_MAKE_EN inserts one all-ones clk between two different valid lines.
module ttl_decoder_scan #(
    parameter int SEL_W   = 4,
    parameter int OUTPUTS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               mode,
    input  logic               load,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               en_n,
    output logic [OUTPUTS-1:0] o,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    localparam logic [SEL_W:0]   N_OUT = (SEL_W+1)'(OUTPUTS);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(OUTPUTS - 1);

    logic [SEL_W-1:0]   code;
    logic [SEL_W-1:0]   code_nxt;
    logic               wrap_nxt;
    logic               code_ok;
    logic [OUTPUTS-1:0] line;
    logic [OUTPUTS-1:0] o_nxt;

    assign code_ok = ({1'b0, code} < N_OUT);
    assign line    = ~({{(OUTPUTS-1){1'b0}}, 1'b1} << code);
    assign cur_sel = code;

    always_comb begin
        code_nxt = code;
        wrap_nxt = 1'b0;
        if (ce) begin
            if (!mode || load) begin
                code_nxt = sel_in;
            end else if (code == LAST) begin
                code_nxt = '0;
                wrap_nxt = 1'b1;
            end else if (!code_ok) begin
                // invalid preload restarts the scan silently
                code_nxt = '0;
            end else begin
                code_nxt = code + 1'b1;
            end
        end
    end

`ifdef TTL_DECODER_BREAK_BEFORE_MAKE_EN
    logic [SEL_W-1:0] shown;
    logic             shown_vld;
    logic [SEL_W-1:0] shown_nxt;
    logic             shown_vld_nxt;

    // shown tracks which line o currently drives low; a change between two live lines blanks first
    always_comb begin
        o_nxt         = '1;
        shown_nxt     = shown;
        shown_vld_nxt = 1'b0;
        if (!en_n && code_ok && !(shown_vld && shown != code)) begin
            o_nxt         = line;
            shown_nxt     = code;
            shown_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shown     <= '0;
            shown_vld <= 1'b0;
        end else begin
            shown     <= shown_nxt;
            shown_vld <= shown_vld_nxt;
        end
    end
`else
    always_comb begin
        o_nxt = '1;
        if (!en_n && code_ok) begin
            o_nxt = line;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            code <= '0;
            wrap <= 1'b0;
            o    <= '1;
        end else begin
            code <= code_nxt;
            wrap <= wrap_nxt;
            o    <= o_nxt;
        end
    end

endmodule

// File: tb/tb_ttl_decoder_scan.sv
// tb/tb_ttl_decoder_scan.sv - table vectors, corner sequences and random run against a reference model
module tb_ttl_decoder_scan;

    localparam int SEL_W   = 4;
    localparam int OUTPUTS = 10;

    logic               clk;
    logic               reset;
    logic               ce;
    logic               mode;
    logic               load;
    logic [SEL_W-1:0]   sel_in;
    logic               en_n;
    logic [OUTPUTS-1:0] o;
    logic [SEL_W-1:0]   cur_sel;
    logic               wrap;

    ttl_decoder_scan #(.SEL_W(SEL_W), .OUTPUTS(OUTPUTS)) dut (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode), .load(load),
        .sel_in(sel_in), .en_n(en_n), .o(o), .cur_sel(cur_sel), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       c;
        logic       m;
        logic       l;
        int         sel;
        logic       en;
        int         exp_cur;
        int         exp_wrap;
        int         exp_o;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    int m_code  = 0;
    int m_wrap  = 0;
    int m_o     = 0;
    int m_shown = -1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic m, input logic l,
                       input int sel, input logic en, input int ec, input int ew, input int eo);
        vec_t v;
        v.r = r; v.c = c; v.m = m; v.l = l; v.sel = sel; v.en = en;
        v.exp_cur = ec; v.exp_wrap = ew; v.exp_o = eo;
        vecs.push_back(v);
    endtask

    // reference: o follows the code held before the edge, code follows the scan rules
    task automatic model_edge(input logic r, input logic c, input logic m, input logic l,
                              input int sel, input logic en);
        int ones;
        ones = (1 << OUTPUTS) - 1;
        if (r) begin
            m_code = 0; m_wrap = 0; m_o = ones; m_shown = -1;
            return;
        end
        if (en || m_code >= OUTPUTS) begin
            m_o = ones; m_shown = -1;
`ifdef TTL_DECODER_BREAK_BEFORE_MAKE_EN
        end else if (m_shown >= 0 && m_shown != m_code) begin
            m_o = ones; m_shown = -1;
`endif
        end else begin
            m_o = ones - (1 << m_code); m_shown = m_code;
        end
        m_wrap = 0;
        if (c) begin
            if (!m || l)                    m_code = sel;
            else if (m_code == OUTPUTS - 1) begin m_code = 0; m_wrap = 1; end
            else if (m_code >= OUTPUTS)     m_code = 0;
            else                            m_code = m_code + 1;
        end
    endtask

    task automatic apply(input logic r, input logic c, input logic m, input logic l,
                         input int sel, input logic en);
        reset = r; ce = c; mode = m; load = l; sel_in = SEL_W'(sel); en_n = en;
        @(posedge clk);
        model_edge(r, c, m, l, sel, en);
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".cur_sel"}, int'(cur_sel), m_code);
        chk({tag, ".wrap"},    int'(wrap),    m_wrap);
        chk({tag, ".o"},       int'(o),       m_o);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; mode = 1'b0; load = 1'b0; sel_in = '0; en_n = 1'b0;

        // scan from reset: cur_sel 1..9,0 with wrap on the return to 0
        add(1, 1, 1, 0, 0, 0, 0, 0, 'h3ff);
        for (int i = 1; i <= 10; i++)
            add(0, 1, 1, 0, 0, 0, i % 10, (i == 10) ? 1 : 0, 'h3ff & ~(1 << (i - 1)));
        add(0, 1, 1, 0, 0, 0, 1, 0, 'h3fe);
        // direct code 5 then invalid 12
        add(0, 1, 0, 0, 5, 0, 5, 0, 'h3fd);
        add(0, 1, 0, 0, 5, 0, 5, 0, 'h3df);
        add(0, 1, 0, 0, 12, 0, 12, 0, 'h3df);
        add(0, 1, 0, 0, 12, 0, 12, 0, 'h3ff);
        // invalid preload 14, scan restarts at 0 without wrap
        add(0, 1, 1, 1, 14, 0, 14, 0, 'h3ff);
        add(0, 1, 1, 0, 0, 0, 0, 0, 'h3ff);
        add(0, 1, 1, 0, 0, 0, 1, 0, 'h3fe);
        // blanked while counting 2..6, then enabled
        add(0, 1, 1, 1, 2, 0, 2, 0, 'h3fd);
        for (int i = 3; i <= 6; i++)
            add(0, 1, 1, 0, 0, 1, i, 0, 'h3ff);
        add(0, 0, 1, 0, 0, 0, 6, 0, 'h3bf);
        // ce toggling, wrap only on a ce edge
        add(0, 1, 1, 0, 0, 0, 7, 0, 'h3bf);
        add(0, 0, 1, 0, 0, 0, 7, 0, 'h37f);
        add(0, 1, 1, 0, 0, 0, 8, 0, 'h37f);
        add(0, 0, 1, 0, 0, 0, 8, 0, 'h2ff);
        add(0, 1, 1, 0, 0, 0, 9, 0, 'h2ff);
        add(0, 0, 1, 0, 0, 0, 9, 0, 'h1ff);
        add(0, 1, 1, 0, 0, 0, 0, 1, 'h1ff);
        add(0, 0, 1, 0, 0, 0, 0, 0, 'h3fe);
        // reset mid-scan at code 7
        add(0, 1, 1, 1, 7, 0, 7, 0, 'h3fe);
        add(1, 1, 1, 0, 0, 0, 0, 0, 'h3ff);
        add(0, 1, 1, 0, 0, 0, 1, 0, 'h3fe);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].c, vecs[i].m, vecs[i].l, vecs[i].sel, vecs[i].en);
            chk($sformatf("vec%0d.cur_sel", i), int'(cur_sel), vecs[i].exp_cur);
            chk($sformatf("vec%0d.wrap", i),    int'(wrap),    vecs[i].exp_wrap);
`ifdef TTL_DECODER_BREAK_BEFORE_MAKE_EN
            chk($sformatf("vec%0d.o", i),       int'(o),       m_o);
`else
            chk($sformatf("vec%0d.o", i),       int'(o),       vecs[i].exp_o);
`endif
        end

        // direct 3 -> 4: gap only with break-before-make
        apply(0, 1, 0, 0, 3, 0);
        apply(0, 1, 0, 0, 3, 0);
        chk("bbm.o3", int'(o), 'h3f7);
        apply(0, 1, 0, 0, 4, 0);
        chk("bbm.hold3", int'(o), 'h3f7);
        apply(0, 1, 0, 0, 4, 0);
`ifdef TTL_DECODER_BREAK_BEFORE_MAKE_EN
        chk("bbm.gap", int'(o), 'h3ff);
`else
        chk("bbm.gap", int'(o), 'h3ef);
`endif
        apply(0, 1, 0, 0, 4, 0);
        chk("bbm.o4", int'(o), 'h3ef);
        chk_model("bbm");

        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 15), ($urandom_range(0, 5) == 0));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
